// File: rtl/key_step_ctrl.sv
// Push-button conditioner for the DE2 step counter: synchronizes and debounces the keys,
// turns a step press into a single pulse with auto-repeat, and adds an optional free-running tick.
module key_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int AUTO_RATE       = 50000000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic key_step_n,
  input  logic key_load_n,
  input  logic run_en,
  output logic step,
  output logic load_n,
  output logic held
);

  localparam int MAX_A  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_F  = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CNT_W  = $clog2(MAX_F);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int PRE_W  = $clog2(AUTO_RATE);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [DB_W-1:0]  LD_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRE_W-1:0] AR_LAST  = PRE_W'(AUTO_RATE - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  logic step_s1_q, step_s2_q;
  logic load_s1_q, load_s2_q;
  logic run_s1_q,  run_s2_q;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DB_W-1:0]   lcnt_q, lcnt_d;
  logic              load_q, load_d;
  logic              step_q, step_d;
  logic              held_q, held_d;
  logic              fsm_pulse;
  logic              auto_pulse;

  // Two-flop synchronizers; keys idle high, run switch idles low
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      step_s1_q <= 1'b1;
      step_s2_q <= 1'b1;
      load_s1_q <= 1'b1;
      load_s2_q <= 1'b1;
      run_s1_q  <= 1'b0;
      run_s2_q  <= 1'b0;
    end else begin
      step_s1_q <= key_step_n;
      step_s2_q <= step_s1_q;
      load_s1_q <= key_load_n;
      load_s2_q <= load_s1_q;
      run_s1_q  <= run_en;
      run_s2_q  <= run_s1_q;
    end
  end

  // Step FSM: one shared counter, cleared whenever the state changes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fsm_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!step_s2_q) state_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (step_s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = HELD;
          cnt_d     = '0;
          fsm_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (step_s2_q) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end else if (cnt_q == RD_LAST) begin
          state_d   = REPEAT;
          cnt_d     = '0;
          fsm_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (step_s2_q) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end else if (cnt_q == RP_LAST) begin
          cnt_d     = '0;
          fsm_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE_DB: begin
        // A low sample only restarts the release filter; it never re-arms a press
        if (!step_s2_q) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pre_d      = '0;
    auto_pulse = 1'b0;
    if (run_s2_q) begin
      if (pre_q == AR_LAST) begin
        auto_pulse = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_comb begin
    load_d = load_q;
    lcnt_d = '0;
    if (load_s2_q != load_q) begin
      if (lcnt_q == LD_LAST) begin
        load_d = load_s2_q;
      end else begin
        lcnt_d = lcnt_q + DB_W'(1);
      end
    end
  end

  // Gate on the next load level so step never overlaps an asserted load_n
  always_comb begin
    step_d = (fsm_pulse | auto_pulse) & load_d;
    held_d = (state_d == HELD) || (state_d == REPEAT);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      lcnt_q  <= '0;
      load_q  <= 1'b1;
      step_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      lcnt_q  <= lcnt_d;
      load_q  <= load_d;
      step_q  <= step_d;
      held_q  <= held_d;
    end
  end

  assign step   = step_q;
  assign load_n = load_q;
  assign held   = held_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Directed bench for key_step_ctrl with short debounce/repeat/auto parameters.
module tb_key_step_ctrl;

  logic CLOCK_50 = 1'b0;
  logic RESET_N;
  logic key_step_n;
  logic key_load_n;
  logic run_en;
  logic step;
  logic load_n;
  logic held;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  key_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8),
    .AUTO_RATE(10)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .key_step_n(key_step_n),
    .key_load_n(key_load_n),
    .run_en(run_en),
    .step(step),
    .load_n(load_n),
    .held(held)
  );

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    RESET_N    = 1'b0;
    key_step_n = 1'b1;
    key_load_n = 1'b1;
    run_en     = 1'b0;
    idle_cycles(3);
    checks++;
    if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b want 0", step); end
    checks++;
    if (load_n !== 1'b1) begin errors++; $display("FAIL reset_load_n got %b want 1", load_n); end
    checks++;
    if (held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", held); end
    RESET_N = 1'b1;
    idle_cycles(10);
    checks++;
    if (step !== 1'b0 || load_n !== 1'b1 || held !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got step=%b load_n=%b held=%b want 0 1 0", step, load_n, held);
    end
  endtask

  task automatic test_clean_press();
    key_step_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLOCK_50);
      checks++;
      if (step !== (i == 7)) begin
        errors++; $display("FAIL clean_step cyc %0d got %b want %b", i, step, (i == 7));
      end
      checks++;
      if (held !== (i >= 7 && i <= 14)) begin
        errors++; $display("FAIL clean_held cyc %0d got %b want %b", i, held, (i >= 7 && i <= 14));
      end
      if (i == 12) key_step_n = 1'b1;
    end
    idle_cycles(10);
  endtask

  task automatic test_bounce();
    key_step_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge CLOCK_50);
      checks++;
      if (step !== 1'b0 || held !== 1'b0) begin
        errors++; $display("FAIL bounce_quiet cyc %0d got step=%b held=%b want 0 0", i, step, held);
      end
      if (i == 2) key_step_n = 1'b1;
      if (i == 3) key_step_n = 1'b0;
      if (i == 6) key_step_n = 1'b1;
    end
    // A clean press now must see the full latency, proving the FSM settled in IDLE
    key_step_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLOCK_50);
      checks++;
      if (step !== (i == 7)) begin
        errors++; $display("FAIL bounce_then_press cyc %0d got %b want %b", i, step, (i == 7));
      end
      if (i == 10) key_step_n = 1'b1;
    end
    idle_cycles(10);
  endtask

  task automatic test_hold_repeat();
    logic exp_s;
    key_step_n = 1'b0;
    for (int i = 1; i <= 90; i++) begin
      @(negedge CLOCK_50);
      exp_s = (i == 7) || (i == 27) || (i == 35) || (i == 43) || (i == 51) || (i == 59);
      checks++;
      if (step !== exp_s) begin
        errors++; $display("FAIL repeat_step cyc %0d got %b want %b", i, step, exp_s);
      end
      checks++;
      if (held !== (i >= 7 && i <= 62)) begin
        errors++; $display("FAIL repeat_held cyc %0d got %b want %b", i, held, (i >= 7 && i <= 62));
      end
      if (i == 60) key_step_n = 1'b1;
    end
    idle_cycles(10);
  endtask

  task automatic test_release_bounce();
    logic exp_h;
    key_step_n = 1'b0;
    for (int i = 1; i <= 75; i++) begin
      @(negedge CLOCK_50);
      exp_h = (i >= 7 && i <= 12) || (i >= 56 && i <= 61);
      checks++;
      if (step !== (i == 7 || i == 56)) begin
        errors++; $display("FAIL relbounce_step cyc %0d got %b want %b", i, step, (i == 7 || i == 56));
      end
      checks++;
      if (held !== exp_h) begin
        errors++; $display("FAIL relbounce_held cyc %0d got %b want %b", i, held, exp_h);
      end
      if (i >= 10 && i <= 29)      key_step_n = (((i - 10) / 2) % 2 == 0);
      else if (i >= 30 && i <= 32) key_step_n = 1'b1;
      else if (i >= 33 && i <= 42) key_step_n = 1'b0;
      else if (i >= 43 && i <= 48) key_step_n = 1'b1;
      else if (i >= 49 && i <= 58) key_step_n = 1'b0;
      else if (i >= 59)            key_step_n = 1'b1;
    end
    idle_cycles(10);
  endtask

  task automatic test_auto_run();
    bit   found;
    logic exp_s;
    logic exp_l;
    found  = 1'b0;
    run_en = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge CLOCK_50);
      if (step === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL auto_first_pulse got none within 30 cycles want one");
    end else begin
      for (int j = 1; j <= 110; j++) begin
        @(negedge CLOCK_50);
        exp_s = (j <= 85) && (j % 10 == 0) && !(j >= 38 && j <= 67);
        exp_l = !(j >= 38 && j <= 67);
        checks++;
        if (step !== exp_s) begin
          errors++; $display("FAIL auto_step cyc %0d got %b want %b", j, step, exp_s);
        end
        checks++;
        if (load_n !== exp_l) begin
          errors++; $display("FAIL auto_load_n cyc %0d got %b want %b", j, load_n, exp_l);
        end
        if (j == 13) key_step_n = 1'b0;
        if (j == 20) key_step_n = 1'b1;
        if (j == 32) key_load_n = 1'b0;
        if (j == 62) key_load_n = 1'b1;
        if (j == 85) run_en     = 1'b0;
      end
    end
    run_en     = 1'b0;
    key_step_n = 1'b1;
    key_load_n = 1'b1;
    idle_cycles(15);
  endtask

  task automatic test_reset_mid_repeat();
    logic exp_s;
    key_step_n = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge CLOCK_50);
      exp_s = (i == 7) || (i == 27) || (i == 35);
      checks++;
      if (step !== exp_s) begin
        errors++; $display("FAIL prereset_step cyc %0d got %b want %b", i, step, exp_s);
      end
    end
    checks++;
    if (held !== 1'b1) begin errors++; $display("FAIL prereset_held got %b want 1", held); end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (step !== 1'b0) begin errors++; $display("FAIL async_reset_step got %b want 0", step); end
    checks++;
    if (held !== 1'b0) begin errors++; $display("FAIL async_reset_held got %b want 0", held); end
    checks++;
    if (load_n !== 1'b1) begin errors++; $display("FAIL async_reset_load_n got %b want 1", load_n); end
    idle_cycles(3);
    RESET_N = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge CLOCK_50);
      exp_s = (i == 7) || (i == 27) || (i == 35) || (i == 43);
      checks++;
      if (step !== exp_s) begin
        errors++; $display("FAIL postreset_step cyc %0d got %b want %b", i, step, exp_s);
      end
      checks++;
      if (held !== (i >= 7)) begin
        errors++; $display("FAIL postreset_held cyc %0d got %b want %b", i, held, (i >= 7));
      end
    end
    key_step_n = 1'b1;
    idle_cycles(15);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_release_bounce();
    test_auto_run();
    test_reset_mid_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
